// File: rtl/psa_pkg.sv
// Package for the pipelined segmented adder.
// Contents:
//   PSA_DEFAULT_WIDTH / PSA_DEFAULT_SEG_WIDTH : default operand and segment widths
//   seg_t                                     : one segment at the default segment width
//   psa_stage_count()                         : pipeline depth for a width/segment pair
package psa_pkg;

    localparam int PSA_DEFAULT_WIDTH     = 64;
    localparam int PSA_DEFAULT_SEG_WIDTH = 16;

    typedef logic [PSA_DEFAULT_SEG_WIDTH-1:0] seg_t;

    // A degenerate segment width still yields a legal depth of one, so that
    // the elaboration error in the top is the only thing that gets reported.
    function automatic int psa_stage_count(input int width, input int seg_width);
        int count_v;
        if (seg_width < 1) begin
            count_v = 1;
        end else if (width < seg_width) begin
            count_v = 1;
        end else begin
            count_v = width / seg_width;
        end
        return count_v;
    endfunction

endpackage

// File: rtl/psa_stage.sv
// One pipeline stage of the segmented adder.
// Adds segment IDX of the operands plus the incoming carry, splices the
// segment result into the partial sum, and registers everything. The full
// operand words ride along so that later stages find their segments.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   advance         1 = load new contents, 0 = hold
//   in_valid        valid bit from the previous stage
//   in_a, in_b      operand words (b already inverted for subtraction)
//   in_sum          partial sum with segments below IDX finished
//   in_carry        carry into this segment
//   out_*           registered versions for the next stage
//   out_ovf         signed overflow as if this segment held the MSB
module psa_stage
    import psa_pkg::*;
#(
    parameter int WIDTH     = PSA_DEFAULT_WIDTH,
    parameter int SEG_WIDTH = PSA_DEFAULT_SEG_WIDTH,
    parameter int IDX       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int LSB = IDX * SEG_WIDTH;

    logic [SEG_WIDTH-1:0] a_seg_s;
    logic [SEG_WIDTH-1:0] b_seg_s;
    logic [SEG_WIDTH-1:0] seg_sum_s;
    logic                 seg_carry_s;
    logic                 msb_cin_s;
    logic [WIDTH-1:0]     sum_next_s;

    logic                 valid_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     sum_r;
    logic                 carry_r;
    logic                 ovf_r;

    assign a_seg_s = in_a[LSB +: SEG_WIDTH];
    assign b_seg_s = in_b[LSB +: SEG_WIDTH];
    assign {seg_carry_s, seg_sum_s} = {1'b0, a_seg_s} + {1'b0, b_seg_s}
                                    + {{SEG_WIDTH{1'b0}}, in_carry};

    // Carry into the top bit of the segment is recovered from its sum bit.
    assign msb_cin_s = seg_sum_s[SEG_WIDTH-1] ^ a_seg_s[SEG_WIDTH-1] ^ b_seg_s[SEG_WIDTH-1];

    // Replace this stage's segment in the partial sum, keep the rest.
    always_comb begin
        sum_next_s                   = in_sum;
        sum_next_s[LSB +: SEG_WIDTH] = seg_sum_s;
    end

    // Stage registers: load together on advance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (advance) begin
            valid_r <= in_valid;
            a_r     <= in_a;
            b_r     <= in_b;
            sum_r   <= sum_next_s;
            carry_r <= seg_carry_s;
            ovf_r   <= msb_cin_s ^ seg_carry_s;
        end
    end

    assign out_valid = valid_r;
    assign out_a     = a_r;
    assign out_b     = b_r;
    assign out_sum   = sum_r;
    assign out_carry = carry_r;
    assign out_ovf   = ovf_r;

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined segmented ripple-carry adder: one SEG_WIDTH segment per stage,
// carry registered between stages, STAGES = WIDTH/SEG_WIDTH cycles latency,
// one result per cycle, valid/ready with full backpressure (the whole
// pipeline advances together or holds).
// Optional feature macro: PSA_SUB_EN adds port 'sub' (1 = a - b; b inverted,
// stage-0 carry forced to 1, c_in ignored).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready is combinational)
//   a, b, c_in          operands and carry into bit 0
//   sub                 only with PSA_SUB_EN
//   out_valid, out_ready output handshake
//   sum, c_out, ovf     registered result, carry out, signed overflow
module pipelined_seg_adder
    import psa_pkg::*;
#(
    parameter int WIDTH     = PSA_DEFAULT_WIDTH,
    parameter int SEG_WIDTH = PSA_DEFAULT_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef PSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = psa_stage_count(WIDTH, SEG_WIDTH);

    if (SEG_WIDTH < 1) begin : g_bad_seg
        $error("pipelined_seg_adder: SEG_WIDTH must be at least 1");
    end else if ((WIDTH % SEG_WIDTH) != 0) begin : g_bad_width
        $error("pipelined_seg_adder: WIDTH must be a multiple of SEG_WIDTH");
    end

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             carry0_s;

    // Element k feeds stage k; element STAGES is the last stage's output.
    logic             valid_chain_s [0:STAGES];
    logic [WIDTH-1:0] a_chain_s     [0:STAGES];
    logic [WIDTH-1:0] b_chain_s     [0:STAGES];
    logic [WIDTH-1:0] sum_chain_s   [0:STAGES];
    logic             carry_chain_s [0:STAGES];
    logic             ovf_chain_s   [1:STAGES];

`ifdef PSA_SUB_EN
    assign b_eff_s  = sub ? ~b : b;
    assign carry0_s = sub ? 1'b1 : c_in;
`else
    assign b_eff_s  = b;
    assign carry0_s = c_in;
`endif

    // Empty bubbles are not collapsed: everything moves only on advance.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    assign valid_chain_s[0] = in_valid;
    assign a_chain_s[0]     = a;
    assign b_chain_s[0]     = b_eff_s;
    assign sum_chain_s[0]   = '0;
    assign carry_chain_s[0] = carry0_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        psa_stage #(
            .WIDTH     (WIDTH),
            .SEG_WIDTH (SEG_WIDTH),
            .IDX       (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance_s),
            .in_valid  (valid_chain_s[k]),
            .in_a      (a_chain_s[k]),
            .in_b      (b_chain_s[k]),
            .in_sum    (sum_chain_s[k]),
            .in_carry  (carry_chain_s[k]),
            .out_valid (valid_chain_s[k+1]),
            .out_a     (a_chain_s[k+1]),
            .out_b     (b_chain_s[k+1]),
            .out_sum   (sum_chain_s[k+1]),
            .out_carry (carry_chain_s[k+1]),
            .out_ovf   (ovf_chain_s[k+1])
        );
    end

    assign out_valid = valid_chain_s[STAGES];
    assign sum       = sum_chain_s[STAGES];
    assign c_out     = carry_chain_s[STAGES];
    assign ovf       = ovf_chain_s[STAGES];

endmodule

// File: tb/tb_pipelined_seg_adder.sv
module tb_pipelined_seg_adder;

    localparam int W  = 64;
    localparam int SW = 16;
    localparam int ST = W / SW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    logic [W+1:0] exp_q [$];
    logic [ST-1:0] hist;
    int            ready_run;
    logic          prev_stall;
    logic [W+1:0]  prev_res;

    pipelined_seg_adder #(.WIDTH(W), .SEG_WIDTH(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef PSA_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, c_out, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic ci, input logic sb);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        logic         o;
        bb   = sb ? ~bv : bv;
        cc   = sb ? 1'b1 : ci;
        full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, cc};
        o    = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
        return {o, full};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        case ($urandom_range(0, 5))
            0:       w = {W{1'b1}};
            1:       w = {1'b0, {(W-1){1'b1}}};
            2:       w = {W{1'b0}};
            default: w = {$urandom, $urandom};
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one operation and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1; a = av; b = bv; c_in = ci;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            n++;
            tick();
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
        end
    endtask

    // Wait for the next result with out_ready=1; report cycles since acceptance.
    task automatic wait_result(output int lat, output logic [W+1:0] res);
        lat = 0;
        res = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                res = {ovf, c_out, sum};
                break;
            end
            tick();
        end
        if (lat == 0) begin
            tests++; fails++;
            $display("FAIL result_timeout: got no out_valid in 20 cycles, expected one");
        end
        tick();
    endtask

    // Scoreboard / protocol checker, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hist       = '0;
            ready_run  = 0;
            prev_stall = 1'b0;
        end else begin
            chk1("in_ready_rule", in_ready, !out_valid || out_ready);
            if (ready_run >= ST) begin
                chk1("latency", out_valid, hist[ST-1]);
            end
            if (prev_stall) begin
                chk1("stall_valid_hold", out_valid, 1'b1);
                chk("stall_data_hold", {ovf, c_out, sum}, prev_res);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL stale_result: got sum=%h, expected no result", sum);
                end else begin
                    chk("result", {ovf, c_out, sum}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_in, sub_v));
            end
            hist       = {hist[ST-2:0], in_valid && in_ready};
            ready_run  = out_ready ? ready_run + 1 : 0;
            prev_stall = out_valid && !out_ready;
            prev_res   = {ovf, c_out, sum};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [W+1:0] res;
        logic [W-1:0] x;
        logic [W-1:0] y;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
        out_ready = 1'b1; sub_v = 1'b0;

        // Pin the reference model with hand-computed values.
        x = {W{1'b1}}; y = 64'd1;
        chk("model_ripple", model(x, y, 1'b0, 1'b0), {1'b0, 1'b1, 64'h0});
        x = 64'h7FFF_FFFF_FFFF_FFFF;
        chk("model_ovf", model(x, y, 1'b0, 1'b0), {1'b1, 1'b0, 64'h8000_0000_0000_0000});
        x = 64'd5; y = 64'd7;
        chk("model_small", model(x, y, 1'b1, 1'b0), {2'b00, 64'd13});

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        chk("reset_sum", {ovf, c_out, sum}, {(W+2){1'b0}});
        tick();

        // Full carry ripple across every stage.
        send({W{1'b1}}, 64'd1, 1'b0);
        in_valid = 1'b0;
        wait_result(lat, res);
        chk("ripple_latency", 66'(lat), 66'(ST));
        chk("ripple_result", res, {1'b0, 1'b1, 64'h0});

        // Signed overflow into the MSB.
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        in_valid = 1'b0;
        wait_result(lat, res);
        chk("ovf_latency", 66'(lat), 66'(ST));
        chk("ovf_result", res, {1'b1, 1'b0, 64'h8000_0000_0000_0000});

`ifdef PSA_SUB_EN
        sub_v = 1'b1;
        send(64'd5, 64'd7, 1'b0);
        in_valid = 1'b0;
        sub_v = 1'b0;
        wait_result(lat, res);
        chk("sub_result", res, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
`endif

        // Back-to-back random operations at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            a = rand_word(); b = rand_word(); c_in = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        repeat (ST + 4) tick();
        chk("b2b_drained", 66'(exp_q.size()), 66'd0);

        // Fill and stall the pipeline, then reset with work in flight.
        out_ready = 1'b0;
        for (int i = 0; i < ST + 2; i++) begin
            in_valid = 1'b1;
            a = rand_word(); b = rand_word(); c_in = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk1("stalled_full", out_valid, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("midstream_reset_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < ST + 4; i++) begin
            @(negedge clk);
            chk1("no_stale_after_reset", out_valid, 1'b0);
            tick();
        end

        // Random backpressure and random input valid.
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) < 6);
            a = rand_word(); b = rand_word(); c_in = 1'($urandom_range(0, 1));
`ifdef PSA_SUB_EN
            sub_v = 1'($urandom_range(0, 1));
`endif
            tick();
        end
        in_valid = 1'b0;
        sub_v = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 6) tick();
        chk("random_drained", 66'(exp_q.size()), 66'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
